// File: rtl/core_msg_rx.sv
// core_msg_rx: core-side receiver for the scheduler-to-core message bus.
// Filters task headers on the core mask, fills the local instruction buffer,
// latches the r0 init value, launches the pipeline and waits for exec_done.
module core_msg_rx #(
   parameter int unsigned CORE_ID     = 0,
   parameter int unsigned CORE_NUM    = 16,
   parameter int unsigned BUS_TO_CORE = 32,
   parameter int unsigned INSTR_SIZE  = 16,
   parameter int unsigned BUF_DEPTH   = 64,
   parameter int unsigned R0_DEPTH    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         msg_valid,
   input  logic [BUS_TO_CORE-1:0]       mess_to_core,
   output logic                         core_reading,
   input  logic [CORE_NUM-1:0]          init_r0_vect,
   input  logic [R0_DEPTH-1:0][15:0]    r0_data,
   output logic                         core_ready,
   output logic                         start,
   output logic [6:0]                   instr_cnt,
   output logic [1:0]                   fence,
   output logic [15:0]                  r0_out,
   output logic                         r0_load,
   input  logic [$clog2(BUF_DEPTH)-1:0] rd_addr,
   output logic [INSTR_SIZE-1:0]        rd_data,
   input  logic                         exec_done,
   output logic                         overflow
);

   localparam int unsigned AW     = $clog2(BUF_DEPTH);
   // Write pointer carries one extra bit so it can sit at BUF_DEPTH when full.
   localparam int unsigned PW     = AW + 1;
   localparam int unsigned R0_IDX = CORE_ID % R0_DEPTH;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StRecv   = 2'd1;
   localparam logic [1:0] StLaunch = 2'd2;
   localparam logic [1:0] StRun    = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [5:0]            rem_q, rem_d;
   logic                  sel_q, sel_d;
   logic [1:0]            fence_q, fence_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [15:0]           r0_q, r0_d;
   logic                  r0_load_q, r0_load_d;
   logic                  ovf_q, ovf_d;
   logic [INSTR_SIZE-1:0] rd_data_q;
   logic [INSTR_SIZE-1:0] mem [BUF_DEPTH];

   logic                  xfer;
   logic                  hdr_sel;
   logic [5:0]            hdr_n;
   logic                  room;
   logic                  wr_en;
   logic [AW-1:0]         wr_addr_lo;
   logic [AW-1:0]         wr_addr_hi;
   logic                  unused_inputs;

   assign unused_inputs = ^{init_r0_vect, r0_data};

   assign core_reading = (state_q == StIdle) || (state_q == StRecv);
   assign xfer         = msg_valid && core_reading;
   assign hdr_sel      = mess_to_core[16 + CORE_ID];
   assign hdr_n        = mess_to_core[5:0];
   // Pointer is always even, so a pair fits while it is at most BUF_DEPTH-2.
   assign room         = wr_ptr_q <= PW'(BUF_DEPTH - 2);
   assign wr_addr_lo   = wr_ptr_q[AW-1:0];
   assign wr_addr_hi   = wr_ptr_q[AW-1:0] + AW'(1);

   // Next-state logic for the receive/launch sequencer and task registers.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      sel_d     = sel_q;
      fence_d   = fence_q;
      wr_ptr_d  = wr_ptr_q;
      r0_d      = r0_q;
      r0_load_d = 1'b0;
      ovf_d     = ovf_q;
      wr_en     = 1'b0;
      case (state_q)
         StIdle: begin
            if (xfer) begin
               rem_d    = hdr_n;
               fence_d  = mess_to_core[7:6];
               sel_d    = hdr_sel;
               wr_ptr_d = '0;
               if (hdr_sel && init_r0_vect[CORE_ID]) begin
                  r0_d      = r0_data[R0_IDX];
                  r0_load_d = 1'b1;
               end
               if (hdr_n != 6'd0) begin
                  state_d = StRecv;
               end else if (hdr_sel) begin
                  state_d = StLaunch;
               end
            end
         end
         StRecv: begin
            if (xfer) begin
               rem_d = rem_q - 6'd1;
               if (sel_q) begin
                  if (room) begin
                     wr_en    = 1'b1;
                     wr_ptr_d = wr_ptr_q + PW'(2);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               // Unselected cores ack every word so the bus never waits on them.
               if (rem_q == 6'd1) begin
                  state_d = sel_q ? StLaunch : StIdle;
               end
            end
         end
         StLaunch: state_d = StRun;
         StRun: begin
            if (exec_done) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Sequencer and task registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         rem_q     <= '0;
         sel_q     <= 1'b0;
         fence_q   <= '0;
         wr_ptr_q  <= '0;
         r0_q      <= '0;
         r0_load_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         sel_q     <= sel_d;
         fence_q   <= fence_d;
         wr_ptr_q  <= wr_ptr_d;
         r0_q      <= r0_d;
         r0_load_q <= r0_load_d;
         ovf_q     <= ovf_d;
      end
   end

   // Instruction buffer: two instructions per accepted bus word, contents not reset.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem[wr_addr_lo] <= mess_to_core[INSTR_SIZE-1:0];
         mem[wr_addr_hi] <= mess_to_core[2*INSTR_SIZE-1:INSTR_SIZE];
      end
   end

   // Registered fetch port; same-cycle write to the read address returns old data.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign core_ready = (state_q == StIdle) || ((state_q == StRecv) && !sel_q);
   assign start      = (state_q == StLaunch);
   assign instr_cnt  = 7'(wr_ptr_q);
   assign fence      = fence_q;
   assign r0_out     = r0_q;
   assign r0_load    = r0_load_q;
   assign rd_data    = rd_data_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_core_msg_rx.sv
// tb_core_msg_rx: directed and randomized tasks for core_msg_rx (CORE_ID=0),
// checked against a task-level model of buffer contents, counts and handshakes.
module tb_core_msg_rx;

   localparam int DEPTH = 64;

   logic              clk;
   logic              reset;
   logic              msg_valid;
   logic [31:0]       mess_to_core;
   logic              core_reading;
   logic [15:0]       init_r0_vect;
   logic [7:0][15:0]  r0_data;
   logic              core_ready;
   logic              start;
   logic [6:0]        instr_cnt;
   logic [1:0]        fence;
   logic [15:0]       r0_out;
   logic              r0_load;
   logic [5:0]        rd_addr;
   logic [15:0]       rd_data;
   logic              exec_done;
   logic              overflow;

   int                vectors;
   int                miscompares;
   logic [15:0]       mbuf [DEPTH];
   logic [31:0]       wq [$];
   logic [15:0]       r0_m;
   logic              ovf_m;

   core_msg_rx #(
      .CORE_ID     (0),
      .CORE_NUM    (16),
      .BUS_TO_CORE (32),
      .INSTR_SIZE  (16),
      .BUF_DEPTH   (DEPTH),
      .R0_DEPTH    (8)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .msg_valid    (msg_valid),
      .mess_to_core (mess_to_core),
      .core_reading (core_reading),
      .init_r0_vect (init_r0_vect),
      .r0_data      (r0_data),
      .core_ready   (core_ready),
      .start        (start),
      .instr_cnt    (instr_cnt),
      .fence        (fence),
      .r0_out       (r0_out),
      .r0_load      (r0_load),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .exec_done    (exec_done),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Send one header plus the words in wq; leaves the DUT in RUN when selected.
   task automatic do_task(input logic [15:0] mask, input int n, input logic [1:0] fnc,
                          input logic init, input logic [15:0] r0v);
      logic sel;
      int   cnt;
      sel = mask[0];
      for (int e = 0; e < 8; e++) r0_data[e] = 16'($urandom);
      r0_data[0]   = r0v;
      init_r0_vect = {16'($urandom) & 16'hFFFE} | {15'd0, init};
      mess_to_core = {mask, 8'($urandom), fnc, 6'(n)};
      msg_valid    = 1'b1;
      chk("hdr_reading", 32'(core_reading), 32'd1);
      tick();
      if (sel && init) r0_m = r0v;
      chk("hdr_r0_out", 32'(r0_out), 32'(r0_m));
      chk("hdr_r0_load", 32'(r0_load), 32'(sel && init));
      chk("hdr_fence", 32'(fence), 32'(fnc));
      chk("hdr_cnt", 32'(instr_cnt), 32'd0);
      chk("hdr_start", 32'(start), 32'(n == 0 && sel));
      chk("hdr_ready", 32'(core_ready), 32'(n > 0 ? !sel : !sel));
      chk("hdr_rd_state", 32'(core_reading), 32'(n > 0 || !sel));
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         mess_to_core = wq[i];
         exec_done    = 1'($urandom);
         tick();
         if (sel) begin
            if (2 * (i + 1) <= DEPTH) begin
               mbuf[2*i]     = wq[i][15:0];
               mbuf[2*i + 1] = wq[i][31:16];
               cnt           = 2 * (i + 1);
            end else begin
               ovf_m = 1'b1;
            end
         end
         chk("w_cnt", 32'(instr_cnt), 32'(cnt));
         chk("w_ovf", 32'(overflow), 32'(ovf_m));
         chk("w_start", 32'(start), 32'(sel && i == n - 1));
         chk("w_ready", 32'(core_ready), 32'(!sel));
         chk("w_r0_load", 32'(r0_load), 32'd0);
      end
      msg_valid = 1'b0;
      exec_done = 1'b0;
      tick();
      chk("post_start", 32'(start), 32'd0);
      chk("post_ready", 32'(core_ready), 32'(!sel));
      chk("post_reading", 32'(core_reading), 32'(!sel));
      if (sel) begin
         for (int k = 0; k < cnt; k++) begin
            rd_addr = 6'(k);
            tick();
            chk("buf", 32'(rd_data), 32'(mbuf[k]));
         end
         chk("run_cnt", 32'(instr_cnt), 32'(cnt));
      end
   endtask

   // Hold a header on the bus during RUN, then finish the task.
   task automatic end_run();
      msg_valid    = 1'b1;
      mess_to_core = 32'($urandom);
      repeat (2) begin
         tick();
         chk("run_reading", 32'(core_reading), 32'd0);
         chk("run_ready", 32'(core_ready), 32'd0);
      end
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      msg_valid = 1'b0;
      chk("done_reading", 32'(core_reading), 32'd1);
      chk("done_ready", 32'(core_ready), 32'd1);
      chk("done_start", 32'(start), 32'd0);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      r0_m         = '0;
      ovf_m        = 1'b0;
      reset        = 1'b1;
      msg_valid    = 1'b0;
      mess_to_core = '0;
      init_r0_vect = '0;
      r0_data      = '0;
      rd_addr      = '0;
      exec_done    = 1'b0;
      tick();
      tick();
      chk("rst_ready", 32'(core_ready), 32'd1);
      chk("rst_reading", 32'(core_reading), 32'd1);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_r0_load", 32'(r0_load), 32'd0);
      chk("rst_cnt", 32'(instr_cnt), 32'd0);
      chk("rst_fence", 32'(fence), 32'd0);
      chk("rst_r0", 32'(r0_out), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      reset = 1'b0;
      tick();

      // Selected two-word task with r0 init.
      wq = {32'h22221111, 32'h44443333};
      do_task(16'h0001, 2, 2'b10, 1'b1, 16'hBEEF);
      chk("t1_r0", 32'(r0_out), 32'h0000BEEF);

      // Header arriving with exec_done is taken only the cycle after.
      msg_valid    = 1'b1;
      mess_to_core = 32'h0001_0000;
      tick();
      chk("t5_blocked", 32'(core_reading), 32'd0);
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      chk("t5_idle_reading", 32'(core_reading), 32'd1);
      chk("t5_no_start", 32'(start), 32'd0);
      tick();
      msg_valid = 1'b0;
      chk("t5_start", 32'(start), 32'd1);
      chk("t5_cnt", 32'(instr_cnt), 32'd0);
      tick();
      chk("t5_run_ready", 32'(core_ready), 32'd0);
      end_run();

      // Same task addressed to another core: acked, ignored.
      wq = {32'h22221111, 32'h44443333};
      do_task(16'h0002, 2, 2'b01, 1'b1, 16'h1234);

      // Zero-length selected task still launches.
      wq = {};
      do_task(16'h0001, 0, 2'b11, 1'b0, 16'h0);
      end_run();

      // Oversized task: buffer fills, overflow sticks, start still issued.
      wq = {};
      for (int i = 0; i < 40; i++) wq.push_back($urandom);
      do_task(16'h8001, 40, 2'b00, 1'b0, 16'h0);
      chk("t4_ovf", 32'(overflow), 32'd1);
      end_run();

      // Randomized tasks.
      for (int t = 0; t < 14; t++) begin
         logic [15:0] mask;
         int          n;
         mask = 16'($urandom);
         n    = $urandom_range(0, 40);
         wq   = {};
         for (int i = 0; i < n; i++) wq.push_back($urandom);
         do_task(mask, n, 2'($urandom), 1'($urandom), 16'($urandom));
         if (mask[0]) end_run();
      end

      // Reset after one of three words drops the task.
      msg_valid    = 1'b1;
      init_r0_vect = 16'h0001;
      mess_to_core = 32'h0001_0003;
      tick();
      mess_to_core = 32'hAAAA5555;
      tick();
      msg_valid = 1'b0;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      r0_m  = '0;
      ovf_m = 1'b0;
      chk("mrst_ready", 32'(core_ready), 32'd1);
      chk("mrst_reading", 32'(core_reading), 32'd1);
      chk("mrst_start", 32'(start), 32'd0);
      chk("mrst_ovf", 32'(overflow), 32'd0);
      chk("mrst_cnt", 32'(instr_cnt), 32'd0);
      chk("mrst_r0", 32'(r0_out), 32'd0);
      repeat (3) begin
         tick();
         chk("mrst_idle_start", 32'(start), 32'd0);
         chk("mrst_idle_ready", 32'(core_ready), 32'd1);
      end

      // Normal operation after reset.
      wq = {32'hCAFE0001, 32'hF00D0002, 32'h12345678};
      do_task(16'h0001, 3, 2'b01, 1'b1, 16'h5A5A);
      end_run();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/core_msg_rx.md
Name: core_msg_rx

Overview:
- Core-side receiver for the scheduler-to-core message bus; one instance per core.
- Accepts task headers and instruction words, filters them on the header core mask, and fills a local instruction buffer.
- Latches the core's r0 init value, then launches the core pipeline and holds core_ready low until the pipeline reports completion.

Parameters:
CORE_ID, 0, index of this core in the scheduler masks
CORE_NUM, 16, number of cores (mask width)
BUS_TO_CORE, 32, message bus width
INSTR_SIZE, 16, instruction width; two instructions per bus word
BUF_DEPTH, 64, instruction buffer entries (power of two, even)
R0_DEPTH, 8, entries in the r0_data vector

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
msg_valid  in  1  mess_to_core carries a valid word
mess_to_core  in  BUS_TO_CORE  header or instruction word
core_reading  out  1  receiver accepts the word this cycle
init_r0_vect  in  CORE_NUM  per-core r0-init request, sampled with the header
r0_data  in  R0_DEPTH x 16  r0 values; this core uses entry CORE_ID % R0_DEPTH
core_ready  out  1  idle, able to take a new task
start  out  1  one-cycle launch pulse to the pipeline
instr_cnt  out  7  instructions stored for the current task
fence  out  2  fence field of the current task
r0_out  out  16  latched r0 value
r0_load  out  1  one-cycle pulse when r0_out updates
rd_addr  in  log2(BUF_DEPTH)  pipeline instruction fetch address
rd_data  out  INSTR_SIZE  buffer[rd_addr], registered, 1-cycle latency
exec_done  in  1  pipeline finished the task
overflow  out  1  sticky: a task exceeded BUF_DEPTH

Behaviour:
- Transfer happens when msg_valid && core_reading.
- core_reading = (state==IDLE) || (state==RECV); it is combinational on state only.
- Header word fields: [5:0] word count N of following words; [7:6] fence; [31:16] core mask.
- Reset: state=IDLE, core_ready=1, core_reading=1, start=0, r0_load=0, instr_cnt=0, fence=0, r0_out=0, overflow=0, wr_ptr=0, rd_data=0. Buffer contents are don't-care.
- Reset mid-task drops the task without a start pulse.

State machine:
- IDLE:
  - On a header transfer: latch N and fence, sel = mask[CORE_ID], wr_ptr=0, instr_cnt=0.
  - If sel && init_r0_vect[CORE_ID]: r0_out <= r0_data[CORE_ID%R0_DEPTH] and pulse r0_load the next cycle.
  - N>0 -> RECV. N==0 && sel -> LAUNCH. N==0 && !sel -> IDLE.
- RECV:
  - Each transfer decrements the remaining count.
  - If sel: write [15:0] to buf[wr_ptr] and [31:16] to buf[wr_ptr+1], wr_ptr += 2, instr_cnt += 2.
  - A write that would exceed BUF_DEPTH is dropped and sets overflow; instr_cnt saturates at BUF_DEPTH.
  - Non-selected cores still ack every word, so a lagging core never stalls the bus.
  - Last word: sel -> LAUNCH, else -> IDLE.
- LAUNCH (1 cycle): start=1, core_ready=0 -> RUN. N==0 still launches with instr_cnt=0.
- RUN: core_ready=0, core_reading=0. exec_done -> IDLE.
  - A header on the bus in that same cycle is not accepted; it is taken next cycle at the earliest.
- exec_done outside RUN is ignored.
- core_ready = (state==IDLE) || (state==RECV && !sel).
- rd_data is valid one cycle after rd_addr. Reads are legal in any state; a read in the same cycle as a write to the same address returns the old data.
- overflow clears only on reset.

Test Plan:
- Header mask=0x0001, N=2, CORE_ID=0, init_r0_vect=0x0001, r0_data[0]=0xBEEF; words 0x22221111, 0x44443333 -> r0_out=0xBEEF with r0_load pulse; buf[0..3]=1111,2222,3333,4444; instr_cnt=4; start one cycle after the last word; core_ready=0 until exec_done.
- Same header, CORE_ID=1 -> all 3 words acked, no buffer writes, no start, core_ready stays 1.
- Header N=0, mask selects core -> start pulse with instr_cnt=0, RUN until exec_done.
- Header N=40, BUF_DEPTH=64 -> buffer full after 32 words, overflow=1, instr_cnt=64, remaining 8 words acked and dropped, start still issued.
- msg_valid held high in RUN -> core_reading=0; exec_done asserted -> header accepted the following cycle.
- reset asserted during RECV after 1 of 3 words -> next cycle IDLE, core_ready=1, no start, overflow=0.
